// File: rtl/upsample_2x_unpack_if.sv
// Valid/ready beat stream used on both sides of the 2x upsampler.
// The master drives data and valid; the slave returns ready.
interface upsample_2x_unpack_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/upsample_2x_unpack.sv
// 2x nearest-neighbour upsampler for channel-packed feature maps.
// One input row (R pixels x CT beats) is captured in a line buffer, then
// replayed twice, with every pixel emitted twice per replay.
module upsample_2x_unpack #(
    parameter int DATA_WIDTH            = 64,
    parameter int WIDTH_FEATURE_SIZE    = 12,
    parameter int WIDTH_CHANNEL_NUM_REG = 10,
    parameter int ADDR_BITS             = 11
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             Next_Reg,
    input  logic                             Start,
    input  logic [WIDTH_FEATURE_SIZE-1:0]    Row_Num_In_REG,
    input  logic [WIDTH_CHANNEL_NUM_REG-1:0] Channel_In_Num_REG,
    upsample_2x_unpack_if.slave              s_bus,
    upsample_2x_unpack_if.master             m_bus,
    output logic                             Last,
    output logic                             Up_Complete
);
    localparam int CT_W   = WIDTH_CHANNEL_NUM_REG - 3;
    localparam int PROD_W = WIDTH_FEATURE_SIZE + CT_W;
    localparam int DEPTH  = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {IDLE, FILL, EMIT} state_t;

    state_t                        state;
    logic [DATA_WIDTH-1:0]         line_buf [DEPTH];

    // Frame geometry latched at Start, stored as terminal counts.
    logic [WIDTH_FEATURE_SIZE-1:0] r_last;
    logic [CT_W-1:0]               ct_last;
    logic [ADDR_BITS-1:0]          ct_step;
    logic [ADDR_BITS-1:0]          row_last;

    // Fill and emit position counters.
    logic [ADDR_BITS-1:0]          wr_addr;
    logic [ADDR_BITS-1:0]          pix_base;
    logic [ADDR_BITS-1:0]          rd_addr;
    logic [CT_W-1:0]               cin;
    logic [WIDTH_FEATURE_SIZE-1:0] col;
    logic [WIDTH_FEATURE_SIZE-1:0] in_row;
    logic                          rep_col;
    logic                          rep_row;

    logic [CT_W-1:0]               start_ct;
    logic [PROD_W-1:0]             start_prod;
    logic                          start_ok;
    logic                          unused_ch_low;

    // Channel count is a multiple of 8, so its low bits carry no information.
    assign unused_ch_low = ^Channel_In_Num_REG[2:0];
    assign start_ct      = Channel_In_Num_REG[WIDTH_CHANNEL_NUM_REG-1:3];
    assign start_prod    = PROD_W'(Row_Num_In_REG) * PROD_W'(start_ct);
    assign start_ok      = Start && (Row_Num_In_REG != '0) && (start_ct != '0)
                           && (32'(start_prod) <= 32'(DEPTH));

    // pix_base tracks col*CT incrementally, so no multiplier sits in the read path.
    assign rd_addr     = pix_base + ADDR_BITS'(cin);
    assign m_bus.data  = line_buf[rd_addr];
    assign m_bus.valid = (state == EMIT);
    assign s_bus.ready = (state == FILL);
    assign Last        = (state == EMIT) && rep_row && rep_col && (col == r_last)
                         && (cin == ct_last) && (in_row == r_last);

    // Line buffer write port; one input row overwrites the previous one.
    // NOTE: the buffer has no reset -- every location is written in FILL before
    // EMIT reads it, so clearing it would only cost logic.
    always_ff @(posedge clk) begin
        if (state == FILL && s_bus.valid) begin
            line_buf[wr_addr] <= s_bus.data;
        end
    end

    // Frame FSM: geometry latch, fill counter, emit counters and completion pulse.
    // NOTE: all state here uses non-blocking assignments so every counter sees
    // the pre-edge value of the others, whatever their order in this block.
    always_ff @(posedge clk) begin
        Up_Complete <= 1'b0;
        if (rst || Next_Reg) begin
            state    <= IDLE;
            r_last   <= '0;
            ct_last  <= '0;
            ct_step  <= '0;
            row_last <= '0;
            wr_addr  <= '0;
            pix_base <= '0;
            cin      <= '0;
            col      <= '0;
            in_row   <= '0;
            rep_col  <= 1'b0;
            rep_row  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        r_last   <= Row_Num_In_REG - WIDTH_FEATURE_SIZE'(1);
                        ct_last  <= start_ct - CT_W'(1);
                        ct_step  <= ADDR_BITS'(start_ct);
                        row_last <= ADDR_BITS'(start_prod - PROD_W'(1));
                        state    <= FILL;
                    end
                end
                FILL: begin
                    if (s_bus.valid) begin
                        if (wr_addr == row_last) begin
                            wr_addr <= '0;
                            state   <= EMIT;
                        end else begin
                            wr_addr <= wr_addr + ADDR_BITS'(1);
                        end
                    end
                end
                EMIT: begin
                    if (m_bus.ready) begin
                        if (cin != ct_last) begin
                            cin <= cin + CT_W'(1);
                        end else begin
                            cin <= '0;
                            if (!rep_col) begin
                                rep_col <= 1'b1;
                            end else begin
                                rep_col <= 1'b0;
                                if (col != r_last) begin
                                    col      <= col + WIDTH_FEATURE_SIZE'(1);
                                    pix_base <= pix_base + ct_step;
                                end else begin
                                    col      <= '0;
                                    pix_base <= '0;
                                    if (!rep_row) begin
                                        rep_row <= 1'b1;
                                    end else begin
                                        rep_row <= 1'b0;
                                        if (in_row != r_last) begin
                                            in_row <= in_row + WIDTH_FEATURE_SIZE'(1);
                                            state  <= FILL;
                                        end else begin
                                            in_row      <= '0;
                                            state       <= IDLE;
                                            Up_Complete <= 1'b1;
                                        end
                                    end
                                end
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_upsample_2x_unpack.sv
// Self-checking bench for upsample_2x_unpack: random pixel data, random
// valid/ready patterns, and an expected stream built from the upsampling rule.
module tb_upsample_2x_unpack;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        Next_Reg = 1'b0;
    logic        Start = 1'b0;
    logic [11:0] Row_Num_In_REG = '0;
    logic [9:0]  Channel_In_Num_REG = '0;
    logic        Last;
    logic        Up_Complete;

    upsample_2x_unpack_if #(.DATA_WIDTH(64)) s_bus ();
    upsample_2x_unpack_if #(.DATA_WIDTH(64)) m_bus ();

    upsample_2x_unpack dut (
        .clk                (clk),
        .rst                (rst),
        .Next_Reg           (Next_Reg),
        .Start              (Start),
        .Row_Num_In_REG     (Row_Num_In_REG),
        .Channel_In_Num_REG (Channel_In_Num_REG),
        .s_bus              (s_bus),
        .m_bus              (m_bus),
        .Last               (Last),
        .Up_Complete        (Up_Complete)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] in_q[$];
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: output row 2y+a, column 2x+b, channel group c is input pixel (y, x, c).
    function automatic void build_expected(input int r, input int ct);
        exp_q.delete();
        for (int oy = 0; oy < 2 * r; oy++)
            for (int ox = 0; ox < 2 * r; ox++)
                for (int c = 0; c < ct; c++)
                    exp_q.push_back(in_q[((oy / 2) * r + (ox / 2)) * ct + c]);
    endfunction

    // Runs one frame; optionally aborts via rst/Next_Reg after abort_in accepted
    // input beats or abort_out transferred output beats.
    task automatic run_frame(input int r, input int ch, input bit stall, input bit early_start,
                             input int abort_in, input int abort_out, input bit use_rst);
        int ct, total_in, total_out, in_idx, out_idx, cycles, bound;
        bit timed_out;
        ct = ch / 8;
        total_in = r * r * ct;
        total_out = 4 * total_in;
        in_idx = 0;
        out_idx = 0;
        cycles = 0;
        timed_out = 1'b0;
        bound = 3 * (total_in + total_out) + 100;
        in_q.delete();
        for (int i = 0; i < total_in; i++) in_q.push_back({$urandom, $urandom});
        build_expected(r, ct);

        Row_Num_In_REG = 12'(r);
        Channel_In_Num_REG = 10'(ch);
        Start = 1'b1;
        @(posedge clk);
        #1 Start = 1'b0;

        while (out_idx < total_out && !timed_out) begin
            if ((abort_in >= 0 && in_idx == abort_in) || (abort_out >= 0 && out_idx == abort_out)) begin
                s_bus.valid = 1'b0;
                if (use_rst) rst = 1'b1;
                else Next_Reg = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                Next_Reg = 1'b0;
                check("abort_m_valid", 64'(m_bus.valid), 64'(0));
                check("abort_s_ready", 64'(s_bus.ready), 64'(0));
                check("abort_last", 64'(Last), 64'(0));
                m_bus.ready = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    check("abort_no_output", 64'(m_bus.valid), 64'(0));
                    check("abort_no_input", 64'(s_bus.ready), 64'(0));
                end
                @(posedge clk);
                #1;
                return;
            end
            s_bus.valid = ($urandom_range(0, 3) != 0);
            s_bus.data = (in_idx < total_in) ? in_q[in_idx] : {$urandom, $urandom};
            m_bus.ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (early_start && out_idx == total_out - 1) Start = 1'b1;
            @(negedge clk);
            if (m_bus.valid) begin
                check("m_data", m_bus.data, exp_q[out_idx]);
                check("last_beat", 64'(Last), 64'(out_idx == total_out - 1));
                check("s_ready_in_emit", 64'(s_bus.ready), 64'(0));
            end else begin
                check("last_idle", 64'(Last), 64'(0));
            end
            check("up_complete_low", 64'(Up_Complete), 64'(0));
            if (m_bus.valid && m_bus.ready) out_idx++;
            if (s_bus.valid && s_bus.ready) in_idx++;
            @(posedge clk);
            #1;
            cycles++;
            if (out_idx < total_out && cycles > bound) begin
                check("frame_timeout", 64'(0), 64'(1));
                timed_out = 1'b1;
            end
        end
        Start = 1'b0;
        s_bus.valid = 1'b0;
        check("input_beats", 64'(in_idx), 64'(total_in));
        if (!timed_out) begin
            check("up_complete_pulse", 64'(Up_Complete), 64'(1));
            check("idle_m_valid", 64'(m_bus.valid), 64'(0));
            check("idle_s_ready", 64'(s_bus.ready), 64'(0));
        end
    endtask

    // Issues a Start that must be rejected and confirms the block stays idle.
    task automatic start_rejected(input int r, input int ch);
        Row_Num_In_REG = 12'(r);
        Channel_In_Num_REG = 10'(ch);
        Start = 1'b1;
        @(posedge clk);
        #1 Start = 1'b0;
        m_bus.ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("reject_s_ready", 64'(s_bus.ready), 64'(0));
            check("reject_m_valid", 64'(m_bus.valid), 64'(0));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        s_bus.valid = 1'b0;
        s_bus.data = '0;
        m_bus.ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_m_valid", 64'(m_bus.valid), 64'(0));
        check("reset_s_ready", 64'(s_bus.ready), 64'(0));
        check("reset_last", 64'(Last), 64'(0));
        check("reset_up_complete", 64'(Up_Complete), 64'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_frame(2, 8, 1'b0, 1'b0, -1, -1, 1'b0);
        run_frame(1, 16, 1'b0, 1'b0, -1, -1, 1'b0);
        run_frame(2, 8, 1'b1, 1'b0, -1, -1, 1'b0);
        run_frame(3, 24, 1'b1, 1'b0, -1, -1, 1'b0);

        start_rejected(2, 0);
        start_rejected(64, 512);
        start_rejected(0, 8);

        // Largest legal row (32 pixels x 64 groups fills the buffer exactly).
        Row_Num_In_REG = 12'd32;
        Channel_In_Num_REG = 10'd512;
        Start = 1'b1;
        @(posedge clk);
        #1 Start = 1'b0;
        check("max_row_accepted", 64'(s_bus.ready), 64'(1));
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("max_row_reset", 64'(s_bus.ready), 64'(0));

        // Reset wins over a simultaneous Start.
        Row_Num_In_REG = 12'd2;
        Channel_In_Num_REG = 10'd8;
        Start = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        rst = 1'b0;
        check("rst_over_start", 64'(s_bus.ready), 64'(0));

        run_frame(2, 8, 1'b0, 1'b0, -1, 4, 1'b1);
        run_frame(2, 8, 1'b0, 1'b0, -1, -1, 1'b0);
        run_frame(2, 8, 1'b0, 1'b0, 1, -1, 1'b0);
        run_frame(2, 8, 1'b1, 1'b0, -1, -1, 1'b0);

        // Start during the final transfer is ignored; the next cycle's Start is taken.
        run_frame(2, 16, 1'b1, 1'b1, -1, -1, 1'b0);
        run_frame(4, 16, 1'b1, 1'b0, -1, -1, 1'b0);
        run_frame(1, 8, 1'b0, 1'b0, -1, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
